// File: rtl/or1200_rst_pkg.sv
`default_nettype none
// ============================================================================
// Module  : or1200_rst_pkg
// Purpose : Shared encodings for the or1200 reset sequencer: FSM state
//           codes and reset-cause codes reported on rst_cause_o.
// Ports   : none (package)
// Rev     : 1.0  initial release
// ============================================================================
package or1200_rst_pkg;

  typedef enum logic [1:0] {
    HOLD    = 2'd0,
    RELEASE = 2'd1,
    RUN     = 2'd2
  } state_t;

  typedef enum logic [1:0] {
    CAUSE_POR = 2'b00,
    CAUSE_SW  = 2'b01,
    CAUSE_WDT = 2'b10
  } cause_t;

endpackage
`default_nettype wire

// File: rtl/or1200_rst_timer.sv
`default_nettype none
// ============================================================================
// Module  : or1200_rst_timer
// Purpose : CNT_W-bit up-counter with synchronous clear, count enable and a
//           saturating limit. hit flags the last count before the limit,
//           so a registered consumer acting on hit lands exactly on the
//           limit-th cycle. A limit of 0 disables hit.
// Ports   : clk_i  - clock
//           rst_i  - synchronous active-high reset (count -> 0)
//           clr    - synchronous clear, wins over en
//           en     - advance the count by one (stops at limit)
//           limit  - saturation value / terminal count
//           count  - current count
//           hit    - count == limit-1 (never when limit == 0)
// Rev     : 1.0  initial release
// ============================================================================
module or1200_rst_timer
  import or1200_rst_pkg::*;
#(
  parameter int CNT_W = 16
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             clr,
  input  logic             en,
  input  logic [CNT_W-1:0] limit,
  output logic [CNT_W-1:0] count,
  output logic             hit
);

  always_ff @(posedge clk_i) begin
    if (rst_i || clr) begin
      count <= '0;
    end else if (en && (count < limit)) begin
      count <= count + CNT_W'(1);
    end
  end

  assign hit = (limit != '0) && (count == (limit - CNT_W'(1)));

endmodule
`default_nettype wire

// File: rtl/or1200_rst_seq.sv
`default_nettype none
// ============================================================================
// Module  : or1200_rst_seq
// Purpose : Reset sequencer for the or1200 SOPC. Holds NUM_CH reset domains
//           asserted for HOLD_CYC cycles after any reset cause, releases
//           them one by one (domain 0 first) every STAGGER_CYC cycles, then
//           runs a watchdog and a sticky run-budget flag.
// Ports   : clk_i        - system clock
//           rst_i        - synchronous active-high master reset
//           sw_rst_req_i - single-cycle software reset request
//           wdt_kick_i   - watchdog service strobe (ignored outside RUN)
//           rst_o        - per-domain reset, active high, registered
//           busy_o       - high while any rst_o bit is asserted
//           run_done_o   - sticky run-budget expiry flag
//           rst_cause_o  - cause of last reset: 00 POR, 01 SW, 10 WDT
// Rev     : 1.0  initial release
// ============================================================================
module or1200_rst_seq
  import or1200_rst_pkg::*;
#(
  parameter int NUM_CH      = 4,
  parameter int HOLD_CYC    = 5,
  parameter int STAGGER_CYC = 2,
  parameter int WDT_CYC     = 1000,
  parameter int RUN_CYC     = 350,
  parameter int CNT_W       = 16
) (
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic              sw_rst_req_i,
  input  logic              wdt_kick_i,
  output logic [NUM_CH-1:0] rst_o,
  output logic              busy_o,
  output logic              run_done_o,
  output logic [1:0]        rst_cause_o
);

  localparam logic [CNT_W-1:0] HOLD_LIM = CNT_W'(HOLD_CYC);
  localparam logic [CNT_W-1:0] REL_LAST = CNT_W'((NUM_CH - 1) * STAGGER_CYC);
  localparam logic [CNT_W-1:0] WDT_LIM  = CNT_W'(WDT_CYC);
  localparam logic [CNT_W-1:0] RUN_LIM  = CNT_W'(RUN_CYC);

  state_t            state;
  state_t            state_nxt;
  logic [NUM_CH-1:0] rst_nxt;
  logic [1:0]        cause_nxt;

  logic [CNT_W-1:0]  seq_cnt;
  logic [CNT_W-1:0]  seq_lim;
  logic              seq_hit;
  logic              seq_clr;
  logic              seq_en;

  logic [CNT_W-1:0]  wdt_cnt;
  logic              wdt_hit;
  logic              wdt_clr;

  logic [CNT_W-1:0]  run_cnt;
  logic              run_hit;
  logic              run_clr;

  logic              in_run;
  logic              wdt_fire;
  logic              restart;

  // Watchdog and run counts are consumed only through their hit flags.
  logic              unused_cnt;
  assign unused_cnt = ^{wdt_cnt, run_cnt};

  assign in_run   = (state == RUN);
  // A kick in the expiry cycle suppresses the fire.
  assign wdt_fire = in_run && wdt_hit && !wdt_kick_i;
  assign restart  = wdt_fire || sw_rst_req_i;

  // --------------------------------------------------------------------------
  // FSM: state register
  // --------------------------------------------------------------------------
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state <= HOLD;
    end else begin
      state <= state_nxt;
    end
  end

  // --------------------------------------------------------------------------
  // FSM: next state and next output values
  // --------------------------------------------------------------------------
  always_comb begin
    state_nxt = state;
    rst_nxt   = rst_o;
    cause_nxt = rst_cause_o;
    seq_lim   = HOLD_LIM;
    unique case (state)
      HOLD: begin
        rst_nxt = '1;
        if (seq_hit) begin
          state_nxt = RELEASE;
        end
      end
      RELEASE: begin
        seq_lim = REL_LAST;
        // Release count only rises, so a dropped bit is never revisited and
        // bits fall in ascending order.
        for (int k = 0; k < NUM_CH; k++) begin
          if (seq_cnt == CNT_W'(k * STAGGER_CYC)) begin
            rst_nxt[k] = 1'b0;
          end
        end
        if (seq_cnt == REL_LAST) begin
          state_nxt = RUN;
        end
      end
      RUN: begin
        rst_nxt = '0;
      end
      default: begin
        state_nxt = HOLD;
        rst_nxt   = '1;
      end
    endcase

    if (restart) begin
      state_nxt = HOLD;
      rst_nxt   = '1;
      cause_nxt = wdt_fire ? CAUSE_WDT : CAUSE_SW;
    end
  end

  // Hold/release counter restarts at every state change and every restart.
  assign seq_clr = restart || (state_nxt != state) || in_run;
  assign seq_en  = !in_run;

  // Watchdog and run counters sit at 0 whenever the FSM is not staying in RUN.
  assign wdt_clr = !in_run || (state_nxt != RUN) || wdt_kick_i;
  assign run_clr = !in_run || (state_nxt != RUN);

  or1200_rst_timer #(.CNT_W(CNT_W)) u_seq_tmr (
    .clk_i (clk_i),
    .rst_i (rst_i),
    .clr   (seq_clr),
    .en    (seq_en),
    .limit (seq_lim),
    .count (seq_cnt),
    .hit   (seq_hit)
  );

  or1200_rst_timer #(.CNT_W(CNT_W)) u_wdt_tmr (
    .clk_i (clk_i),
    .rst_i (rst_i),
    .clr   (wdt_clr),
    .en    (in_run),
    .limit (WDT_LIM),
    .count (wdt_cnt),
    .hit   (wdt_hit)
  );

  or1200_rst_timer #(.CNT_W(CNT_W)) u_run_tmr (
    .clk_i (clk_i),
    .rst_i (rst_i),
    .clr   (run_clr),
    .en    (in_run),
    .limit (RUN_LIM),
    .count (run_cnt),
    .hit   (run_hit)
  );

  // --------------------------------------------------------------------------
  // Registered outputs
  // --------------------------------------------------------------------------
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      rst_o       <= '1;
      busy_o      <= 1'b1;
      run_done_o  <= 1'b0;
      rst_cause_o <= CAUSE_POR;
    end else begin
      rst_o       <= rst_nxt;
      busy_o      <= |rst_nxt;
      run_done_o  <= run_done_o | (in_run & run_hit);
      rst_cause_o <= cause_nxt;
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_or1200_rst_seq.sv
`default_nettype none
// ============================================================================
// Module  : tb_or1200_rst_seq
// Purpose : Self-checking bench for or1200_rst_seq. Three instances:
//           A defaults, B with WDT_CYC=20, C with HOLD_CYC=1, STAGGER_CYC=0
//           and watchdog/run budget disabled. Each is tracked by an
//           elapsed-time reference model.
// Rev     : 1.0  initial release
// ============================================================================
module tb_or1200_rst_seq;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic rst_v  [3];
  logic sw_v   [3];
  logic kick_v [3];

  logic [3:0] ro0, ro1, ro2;
  logic       bz0, bz1, bz2;
  logic       dn0, dn1, dn2;
  logic [1:0] cs0, cs1, cs2;
  logic [7:0] obs [3];

  assign obs[0] = {ro0, bz0, dn0, cs0};
  assign obs[1] = {ro1, bz1, dn1, cs1};
  assign obs[2] = {ro2, bz2, dn2, cs2};

  or1200_rst_seq dut_a (
    .clk_i(clk), .rst_i(rst_v[0]), .sw_rst_req_i(sw_v[0]), .wdt_kick_i(kick_v[0]),
    .rst_o(ro0), .busy_o(bz0), .run_done_o(dn0), .rst_cause_o(cs0));

  or1200_rst_seq #(.WDT_CYC(20)) dut_b (
    .clk_i(clk), .rst_i(rst_v[1]), .sw_rst_req_i(sw_v[1]), .wdt_kick_i(kick_v[1]),
    .rst_o(ro1), .busy_o(bz1), .run_done_o(dn1), .rst_cause_o(cs1));

  or1200_rst_seq #(.HOLD_CYC(1), .STAGGER_CYC(0), .WDT_CYC(0), .RUN_CYC(0)) dut_c (
    .clk_i(clk), .rst_i(rst_v[2]), .sw_rst_req_i(sw_v[2]), .wdt_kick_i(kick_v[2]),
    .rst_o(ro2), .busy_o(bz2), .run_done_o(dn2), .rst_cause_o(cs2));

  int errors = 0;
  int checks = 0;

  // Instance parameters as seen by the model
  int ph [3] = '{5, 5, 1};
  int ps [3] = '{2, 2, 0};
  int pw [3] = '{1000, 20, 0};
  int pr [3] = '{350, 350, 0};

  // Model: m_e = edges since the last reset cause, m_ref = edge at which the
  // watchdog interval last restarted (RUN entry or kick).
  int         m_e    [3];
  int         m_ref  [3];
  logic       m_done [3];
  logic [1:0] m_cause[3];

  task automatic model_step();
    for (int i = 0; i < 3; i++) begin
      int   rs;
      logic run, fire;
      rs = ph[i] + 1 + 3 * ps[i];
      if (rst_v[i]) begin
        m_e[i] = 0; m_ref[i] = rs; m_done[i] = 1'b0; m_cause[i] = 2'b00;
      end else begin
        run  = (m_e[i] >= rs);
        fire = run && (pw[i] > 0) && ((m_e[i] - m_ref[i]) == pw[i] - 1) && !kick_v[i];
        if (run && (pr[i] > 0) && ((m_e[i] - rs) == pr[i] - 1)) m_done[i] = 1'b1;
        if (fire || sw_v[i]) begin
          m_e[i] = 0; m_ref[i] = rs; m_cause[i] = fire ? 2'b10 : 2'b01;
        end else begin
          if (run && kick_v[i]) m_ref[i] = m_e[i] + 1;
          m_e[i] = m_e[i] + 1;
        end
      end
    end
  endtask

  function automatic logic [7:0] exp_vec(int i);
    logic [3:0] b;
    for (int k = 0; k < 4; k++) b[k] = (m_e[i] < ph[i] + 1 + k * ps[i]);
    return {b, |b, m_done[i], m_cause[i]};
  endfunction

  // Expected default-parameter rst_o n edges after a reset cause ends/starts
  function automatic logic [3:0] seq_rst(int n);
    if (n <= 5)  return 4'hF;
    if (n <= 7)  return 4'hE;
    if (n <= 9)  return 4'hC;
    if (n <= 11) return 4'h8;
    return 4'h0;
  endfunction

  task automatic tick();
    @(posedge clk);
    model_step();
    #1;
  endtask

  task automatic set_all(input logic r);
    for (int i = 0; i < 3; i++) begin
      rst_v[i] = r; sw_v[i] = 1'b0; kick_v[i] = 1'b0;
    end
  endtask

  task automatic fresh_por();
    set_all(1'b1);
    repeat (2) tick();
    set_all(1'b0);
  endtask

  task automatic test_reset();
    set_all(1'b1);
    repeat (10) begin
      tick();
      for (int i = 0; i < 3; i++) begin
        checks++;
        if (obs[i] !== 8'b1111_1_0_00) begin
          errors++;
          $display("FAIL reset_state inst%0d: got %b expected %b", i, obs[i], 8'b1111_1_0_00);
        end
      end
    end
  endtask

  task automatic test_por();
    set_all(1'b0);
    for (int n = 1; n <= 14; n++) begin
      tick();
      checks++;
      if ({ro0, bz0, cs0} !== {seq_rst(n), (n < 12), 2'b00}) begin
        errors++;
        $display("FAIL por_seq n=%0d: got rst=%h busy=%b cause=%b expected rst=%h busy=%b cause=00",
                 n, ro0, bz0, cs0, seq_rst(n), (n < 12));
      end
      checks++;
      if (ro2 !== ((n < 2) ? 4'hF : 4'h0)) begin
        errors++;
        $display("FAIL por_stagger0 n=%0d: got %h expected %h", n, ro2, (n < 2) ? 4'hF : 4'h0);
      end
      for (int i = 0; i < 3; i++) begin
        checks++;
        if (obs[i] !== exp_vec(i)) begin
          errors++;
          $display("FAIL por_model inst%0d n=%0d: got %b expected %b", i, n, obs[i], exp_vec(i));
        end
      end
    end
  endtask

  task automatic test_run_budget();
    fresh_por();
    for (int n = 1; n <= 400; n++) begin
      tick();
      checks++;
      if (dn0 !== (n >= 362)) begin
        errors++;
        $display("FAIL run_done n=%0d: got %b expected %b", n, dn0, (n >= 362));
      end
      for (int i = 0; i < 3; i++) begin
        checks++;
        if (obs[i] !== exp_vec(i)) begin
          errors++;
          $display("FAIL budget_model inst%0d n=%0d: got %b expected %b", i, n, obs[i], exp_vec(i));
        end
      end
    end
  endtask

  task automatic test_sw_reset();
    sw_v[0] = 1'b1;
    tick();
    sw_v[0] = 1'b0;
    checks++;
    if ({ro0, bz0, dn0, cs0} !== 8'b1111_1_1_01) begin
      errors++;
      $display("FAIL sw_entry: got %b expected %b", {ro0, bz0, dn0, cs0}, 8'b1111_1_1_01);
    end
    for (int n = 1; n <= 14; n++) begin
      tick();
      checks++;
      if ({ro0, dn0, cs0} !== {seq_rst(n), 1'b1, 2'b01}) begin
        errors++;
        $display("FAIL sw_reseq n=%0d: got rst=%h done=%b cause=%b expected rst=%h done=1 cause=01",
                 n, ro0, dn0, cs0, seq_rst(n));
      end
      for (int i = 0; i < 3; i++) begin
        checks++;
        if (obs[i] !== exp_vec(i)) begin
          errors++;
          $display("FAIL sw_model inst%0d n=%0d: got %b expected %b", i, n, obs[i], exp_vec(i));
        end
      end
    end
  endtask

  task automatic test_watchdog();
    fresh_por();
    for (int n = 1; n <= 32; n++) begin
      tick();
      checks++;
      if (n < 32 && ro1 !== seq_rst(n)) begin
        errors++;
        $display("FAIL wdt_pre n=%0d: got %h expected %h", n, ro1, seq_rst(n));
      end else if (n == 32 && {ro1, cs1} !== 6'b1111_10) begin
        errors++;
        $display("FAIL wdt_fire: got rst=%h cause=%b expected rst=f cause=10", ro1, cs1);
      end
      for (int i = 0; i < 3; i++) begin
        checks++;
        if (obs[i] !== exp_vec(i)) begin
          errors++;
          $display("FAIL wdt_model inst%0d n=%0d: got %b expected %b", i, n, obs[i], exp_vec(i));
        end
      end
    end
    // Kicked every 10 cycles: no further watchdog reset
    for (int m = 1; m <= 520; m++) begin
      kick_v[1] = (m % 10 == 0);
      tick();
      if (m >= 12) begin
        checks++;
        if (ro1 !== 4'h0) begin
          errors++;
          $display("FAIL wdt_kicked m=%0d: got %h expected 0", m, ro1);
        end
      end
      for (int i = 0; i < 3; i++) begin
        checks++;
        if (obs[i] !== exp_vec(i)) begin
          errors++;
          $display("FAIL kick_model inst%0d m=%0d: got %b expected %b", i, m, obs[i], exp_vec(i));
        end
      end
    end
    kick_v[1] = 1'b0;
  endtask

  task automatic test_restart_mid_release();
    fresh_por();
    repeat (8) tick();
    checks++;
    if (ro0 !== 4'hC) begin
      errors++;
      $display("FAIL restart_pre: got %h expected c", ro0);
    end
    sw_v[0] = 1'b1;
    tick();
    sw_v[0] = 1'b0;
    checks++;
    if ({ro0, cs0} !== 6'b1111_01) begin
      errors++;
      $display("FAIL restart_entry: got rst=%h cause=%b expected rst=f cause=01", ro0, cs0);
    end
    for (int n = 1; n <= 13; n++) begin
      tick();
      checks++;
      if (ro0 !== seq_rst(n)) begin
        errors++;
        $display("FAIL restart_reseq n=%0d: got %h expected %h", n, ro0, seq_rst(n));
      end
      for (int i = 0; i < 3; i++) begin
        checks++;
        if (obs[i] !== exp_vec(i)) begin
          errors++;
          $display("FAIL restart_model inst%0d n=%0d: got %b expected %b", i, n, obs[i], exp_vec(i));
        end
      end
    end
  endtask

  task automatic test_collisions();
    // SW request in the watchdog fire cycle: WDT wins
    fresh_por();
    repeat (31) tick();
    sw_v[1] = 1'b1;
    tick();
    sw_v[1] = 1'b0;
    checks++;
    if ({ro1, cs1} !== 6'b1111_10) begin
      errors++;
      $display("FAIL coll_sw_wdt: got rst=%h cause=%b expected rst=f cause=10", ro1, cs1);
    end
    // Kick in the expiry cycle: no reset
    repeat (31) tick();
    kick_v[1] = 1'b1;
    tick();
    kick_v[1] = 1'b0;
    for (int n = 0; n <= 15; n++) begin
      if (n > 0) tick();
      checks++;
      if ({ro1, cs1} !== 6'b0000_10) begin
        errors++;
        $display("FAIL coll_kick n=%0d: got rst=%h cause=%b expected rst=0 cause=10", n, ro1, cs1);
      end
      checks++;
      if (obs[1] !== exp_vec(1)) begin
        errors++;
        $display("FAIL coll_kick_model n=%0d: got %b expected %b", n, obs[1], exp_vec(1));
      end
    end
    // rst_i mid-release after the run budget expired
    fresh_por();
    repeat (362) tick();
    checks++;
    if (dn0 !== 1'b1) begin
      errors++;
      $display("FAIL coll_done_set: got %b expected 1", dn0);
    end
    sw_v[0] = 1'b1;
    tick();
    sw_v[0] = 1'b0;
    repeat (8) tick();
    checks++;
    if ({ro0, dn0} !== 5'b1100_1) begin
      errors++;
      $display("FAIL coll_mid_rel: got rst=%h done=%b expected rst=c done=1", ro0, dn0);
    end
    rst_v[0] = 1'b1;
    tick();
    rst_v[0] = 1'b0;
    checks++;
    if ({ro0, bz0, dn0, cs0} !== 8'b1111_1_0_00) begin
      errors++;
      $display("FAIL coll_rst: got %b expected %b", {ro0, bz0, dn0, cs0}, 8'b1111_1_0_00);
    end
  endtask

  task automatic test_random();
    set_all(1'b0);
    for (int n = 0; n < 3000; n++) begin
      for (int i = 0; i < 3; i++) begin
        rst_v[i]  = ($urandom_range(0, 299) == 0);
        sw_v[i]   = ($urandom_range(0, 79) == 0);
        kick_v[i] = ($urandom_range(0, 6) == 0);
      end
      tick();
      for (int i = 0; i < 3; i++) begin
        checks++;
        if (obs[i] !== exp_vec(i)) begin
          errors++;
          $display("FAIL random_model inst%0d n=%0d: got %b expected %b", i, n, obs[i], exp_vec(i));
        end
      end
    end
    set_all(1'b0);
  endtask

  initial begin
    set_all(1'b1);
    test_reset();
    test_por();
    test_run_budget();
    test_sw_reset();
    test_watchdog();
    test_restart_mid_release();
    test_collisions();
    test_random();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
`default_nettype wire
